// File: rtl/wm_pkg.sv
// Shared types for the washing machine sequencer: state encoding and the
// actuator pattern each state drives.
package wm_pkg;

    typedef enum logic [2:0] {
        CHECK_DOOR    = 3'd0,
        FILL_WATER    = 3'd1,
        ADD_DETERGENT = 3'd2,
        CYCLE         = 3'd3,
        DRAIN_WATER   = 3'd4,
        SPIN          = 3'd5
    } wm_state_e;

    typedef struct packed {
        logic door_lock;
        logic motor_on;
        logic fill_valve_on;
        logic drain_valve_on;
    } wm_act_t;

    // Field order: door_lock, motor_on, fill_valve_on, drain_valve_on.
    localparam wm_act_t ACT_IDLE   = '{1'b0, 1'b0, 1'b0, 1'b0};
    localparam wm_act_t ACT_FILL   = '{1'b1, 1'b0, 1'b1, 1'b0};
    localparam wm_act_t ACT_DETERG = '{1'b1, 1'b0, 1'b0, 1'b0};
    localparam wm_act_t ACT_CYCLE  = '{1'b1, 1'b1, 1'b0, 1'b0};
    localparam wm_act_t ACT_DRAIN  = '{1'b1, 1'b0, 1'b0, 1'b1};
    localparam wm_act_t ACT_SPIN   = '{1'b1, 1'b1, 1'b0, 1'b1};

endpackage

// File: rtl/wm_output_decode.sv
// Moore output decode: maps the current state onto the four actuator lines.
module wm_output_decode
    import wm_pkg::*;
(
    input  wm_state_e i_state,
    output logic      o_door_lock,
    output logic      o_motor_on,
    output logic      o_fill_valve_on,
    output logic      o_drain_valve_on
);

    wm_act_t w_act;

    always_comb begin
        w_act = ACT_IDLE;
        case (i_state)
            FILL_WATER:    w_act = ACT_FILL;
            ADD_DETERGENT: w_act = ACT_DETERG;
            CYCLE:         w_act = ACT_CYCLE;
            DRAIN_WATER:   w_act = ACT_DRAIN;
            SPIN:          w_act = ACT_SPIN;
            default:       w_act = ACT_IDLE;
        endcase
    end

    assign o_door_lock      = w_act.door_lock;
    assign o_motor_on       = w_act.motor_on;
    assign o_fill_valve_on  = w_act.fill_valve_on;
    assign o_drain_valve_on = w_act.drain_valve_on;

endmodule

// File: rtl/washing_machine.sv
// Front-loader sequencing FSM: state register, wash/rinse flags and done pulse.
// Optional rinse pass is enabled by defining WM_RINSE_EN.
module washing_machine
    import wm_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic door_close,
    input  logic start,
    input  logic filled,
    input  logic detergent_added,
    input  logic cycle_timeout,
    input  logic drained,
    input  logic spin_timeout,
    output logic door_lock,
    output logic motor_on,
    output logic fill_valve_on,
    output logic drain_valve_on,
    output logic done,
    output logic soap_wash,
    output logic water_wash
);

    wm_state_e r_state;
    wm_state_e w_state_next;
    logic      r_soap_wash;
    logic      r_done;
    logic      w_soap_set;
    logic      w_cycle_end;
`ifdef WM_RINSE_EN
    logic      r_water_wash;
    logic      w_water_set;
`endif

    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        w_state_next = r_state;
        w_soap_set   = 1'b0;
        w_cycle_end  = 1'b0;
`ifdef WM_RINSE_EN
        w_water_set  = 1'b0;
`endif
        case (r_state)
            CHECK_DOOR: begin
                if (start && door_close) w_state_next = FILL_WATER;
            end
            FILL_WATER: begin
                if (filled) begin
`ifdef WM_RINSE_EN
                    if (r_soap_wash) begin
                        w_state_next = CYCLE;
                        w_water_set  = 1'b1;
                    end else begin
                        w_state_next = ADD_DETERGENT;
                    end
`else
                    w_state_next = ADD_DETERGENT;
`endif
                end
            end
            ADD_DETERGENT: begin
                if (detergent_added) begin
                    w_state_next = CYCLE;
                    w_soap_set   = 1'b1;
                end
            end
            CYCLE: begin
                if (cycle_timeout) w_state_next = DRAIN_WATER;
            end
            DRAIN_WATER: begin
                if (drained) begin
`ifdef WM_RINSE_EN
                    w_state_next = r_water_wash ? SPIN : FILL_WATER;
`else
                    w_state_next = SPIN;
`endif
                end
            end
            SPIN: begin
                if (spin_timeout) begin
                    w_state_next = CHECK_DOOR;
                    w_cycle_end  = 1'b1;
                end
            end
            default: w_state_next = CHECK_DOOR;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= CHECK_DOOR;
            r_soap_wash <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignment so all registers update from pre-edge values.
            r_state <= w_state_next;
            r_done  <= w_cycle_end;
            if (w_cycle_end)     r_soap_wash <= 1'b0;
            else if (w_soap_set) r_soap_wash <= 1'b1;
        end
    end

`ifdef WM_RINSE_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset)            r_water_wash <= 1'b0;
        else if (w_cycle_end) r_water_wash <= 1'b0;
        else if (w_water_set) r_water_wash <= 1'b1;
    end

    assign water_wash = r_water_wash;
`else
    assign water_wash = 1'b0;
`endif

    assign soap_wash = r_soap_wash;
    assign done      = r_done;

    wm_output_decode u_output_decode (
        .i_state          (r_state),
        .o_door_lock      (door_lock),
        .o_motor_on       (motor_on),
        .o_fill_valve_on  (fill_valve_on),
        .o_drain_valve_on (drain_valve_on)
    );

endmodule

// File: tb/tb_washing_machine.sv
// Self-checking bench for washing_machine; expectations follow WM_RINSE_EN.
module tb_washing_machine;

    logic clk = 1'b0;
    logic reset;
    logic door_close, start, filled, detergent_added;
    logic cycle_timeout, drained, spin_timeout;
    logic door_lock, motor_on, fill_valve_on, drain_valve_on;
    logic done, soap_wash, water_wash;

    washing_machine dut (
        .clk             (clk),
        .reset           (reset),
        .door_close      (door_close),
        .start           (start),
        .filled          (filled),
        .detergent_added (detergent_added),
        .cycle_timeout   (cycle_timeout),
        .drained         (drained),
        .spin_timeout    (spin_timeout),
        .door_lock       (door_lock),
        .motor_on        (motor_on),
        .fill_valve_on   (fill_valve_on),
        .drain_valve_on  (drain_valve_on),
        .done            (done),
        .soap_wash       (soap_wash),
        .water_wash      (water_wash)
    );

    always #5 clk = ~clk;

    // Input vector: {door_close, start, filled, detergent_added, cycle_timeout, drained, spin_timeout}
    localparam logic [6:0] I_NONE  = 7'b000_0000;
    localparam logic [6:0] I_START = 7'b010_0000;
    localparam logic [6:0] I_GO    = 7'b110_0000;
    localparam logic [6:0] I_FILL  = 7'b001_0000;
    localparam logic [6:0] I_DET   = 7'b000_1000;
    localparam logic [6:0] I_CTO   = 7'b000_0100;
    localparam logic [6:0] I_DRN   = 7'b000_0010;
    localparam logic [6:0] I_SPN   = 7'b000_0001;
    localparam logic [6:0] I_ALL   = 7'b111_1111;

    // Observed vector: {door_lock, motor_on, fill_valve_on, drain_valve_on, done, soap_wash, water_wash}
    localparam logic [6:0] E_IDLE = 7'b0000_000;
    localparam logic [6:0] E_FILL = 7'b1010_000;
    localparam logic [6:0] E_ADD  = 7'b1000_000;
    localparam logic [6:0] E_CYC  = 7'b1100_000;
    localparam logic [6:0] E_DRN  = 7'b1001_000;
    localparam logic [6:0] E_SPN  = 7'b1101_000;
    localparam logic [6:0] F_D    = 7'b0000_100;
    localparam logic [6:0] F_S    = 7'b0000_010;
    localparam logic [6:0] F_W    = 7'b0000_001;

    logic [6:0] seq_stim [8] = '{I_FILL, I_DET, I_CTO, I_DRN, I_FILL, I_CTO, I_DRN, I_SPN};
`ifdef WM_RINSE_EN
    logic [6:0] seq_exp [8] = '{E_ADD, E_CYC|F_S, E_DRN|F_S, E_FILL|F_S,
                                E_CYC|F_S|F_W, E_DRN|F_S|F_W, E_SPN|F_S|F_W, E_IDLE|F_D};
    localparam int N_ALL = 10;
    logic [6:0] all_exp [10] = '{E_FILL, E_ADD, E_CYC|F_S, E_DRN|F_S, E_FILL|F_S,
                                 E_CYC|F_S|F_W, E_DRN|F_S|F_W, E_SPN|F_S|F_W, E_IDLE|F_D, E_FILL};
`else
    logic [6:0] seq_exp [8] = '{E_ADD, E_CYC|F_S, E_DRN|F_S, E_SPN|F_S,
                                E_SPN|F_S, E_SPN|F_S, E_SPN|F_S, E_IDLE|F_D};
    localparam int N_ALL = 7;
    logic [6:0] all_exp [10] = '{E_FILL, E_ADD, E_CYC|F_S, E_DRN|F_S, E_SPN|F_S,
                                 E_IDLE|F_D, E_FILL, E_IDLE, E_IDLE, E_IDLE};
`endif

    typedef struct {
        string      tag;
        logic [6:0] exp;
    } sb_item_t;

    sb_item_t   sb_q[$];
    int         total = 0;
    int         bad   = 0;
    logic [6:0] w_obs;

    assign w_obs = {door_lock, motor_on, fill_valve_on, drain_valve_on, done, soap_wash, water_wash};

    task automatic check(input string tag, input logic [6:0] got, input logic [6:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%b expected=%b", tag, got, exp);
        end
    endtask

    task automatic drive(input logic [6:0] ins);
        {door_close, start, filled, detergent_added, cycle_timeout, drained, spin_timeout} = ins;
    endtask

    // Drive inputs, queue the expectation, then compare once the edge has passed.
    task automatic step(input string tag, input logic [6:0] ins, input logic [6:0] exp);
        sb_item_t it;
        drive(ins);
        it.tag = tag;
        it.exp = exp;
        sb_q.push_back(it);
        @(posedge clk);
        #1;
        it = sb_q.pop_front();
        check(it.tag, w_obs, it.exp);
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        #2;
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        drive(I_NONE);
        @(posedge clk);
        #1;
        check("reset_hold", w_obs, E_IDLE);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) step("idle_no_start", I_NONE, E_IDLE);

        for (int i = 0; i < 5; i++) step("door_open", I_START, E_IDLE);
        step("door_closed_go", I_GO, E_FILL);

        for (int i = 0; i < 8; i++) begin
            step($sformatf("seq%0d", i), seq_stim[i], seq_exp[i]);
            if (i < 7) step($sformatf("hold%0d", i), I_NONE, seq_exp[i]);
        end
        step("after_done", I_NONE, E_IDLE);

        step("mid_go", I_GO, E_FILL);
        step("mid_fill", I_FILL, E_ADD);
        step("mid_det", I_DET, E_CYC | F_S);
        #3;
        reset = 1'b1;
        #1;
        check("async_reset", w_obs, E_IDLE);
        @(posedge clk);
        #1;
        check("reset_held", w_obs, E_IDLE);
        reset = 1'b0;
        step("post_reset_idle", I_NONE, E_IDLE);
        step("post_reset_go", I_GO, E_FILL);
        step("flags_cleared", I_FILL, E_ADD);
        pulse_reset();
        check("reset_pulse", w_obs, E_IDLE);

        for (int i = 0; i < N_ALL; i++) step($sformatf("all_high%0d", i), I_ALL, all_exp[i]);
        pulse_reset();
        check("final_reset", w_obs, E_IDLE);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
